// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side ready/valid handshakes of the instruction queue.
// slave is the queue's view; master is the environment (fetch + decode) view.
interface fetch_queue_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_pc_i;
  logic [31:0] in_instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;

  modport slave (
    input  in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o
  );

  modport master (
    output in_valid_i, in_pc_i, in_instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} queue from fetch to decode; 1-cycle push-to-head latency, no bypass.
// in_ready_o depends only on local fullness (no decode-to-fetch path); single-cycle flush.
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  fetch_queue_if.slave     q,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o,
  output logic             full_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam entry_t         RESET_ENTRY = '{pc: 32'h0000_0000, instr: 32'h0000_0013};
  localparam logic [PTR_W:0] FULL_CNT    = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             push;
  logic             pop;

  always_comb begin
    empty_o       = (count_q == '0);
    full_o        = (count_q == FULL_CNT);
    count_o       = count_q;
    q.in_ready_o  = rst_n && !full_o;
    // Hide the head during a flush so decode never takes a wrong-path entry.
    q.out_valid_o = !empty_o && !flush_i;
    q.out_pc_o    = mem_q[rd_ptr_q].pc;
    q.out_instr_o = mem_q[rd_ptr_q].instr;

    push = q.in_valid_i && q.in_ready_o && !flush_i;
    pop  = q.out_valid_o && q.out_ready_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{pc: q.in_pc_i, instr: q.in_instr_i};
    end

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_ENTRY;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written reset sequence, random vs queue model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  logic       empty;
  logic       full;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .q       (bus.slave),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (count <= 3'(DEPTH)) else $error("count_o above DEPTH: %0d", count);
    assert (!(bus.in_valid_i && bus.in_ready_o && !flush && full)) else $error("push while full");
    assert (!(bus.out_valid_o && bus.out_ready_i && empty)) else $error("pop while empty");
  end

  typedef struct {
    logic        flush;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ev;
    logic        eir;
    logic [2:0]  ecnt;
    logic        chkd;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic void add(input logic f, input logic iv, input logic o,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic ev, input logic eir, input int ecnt,
                              input logic cd, input logic [31:0] epc, input logic [31:0] ein);
    vec_t v;
    v.flush = f; v.iv = iv; v.ordy = o; v.pc = pc; v.instr = instr;
    v.ev = ev; v.eir = eir; v.ecnt = 3'(ecnt); v.chkd = cd; v.epc = epc; v.einstr = ein;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic f, input logic iv, input logic o,
                       input logic [31:0] pc, input logic [31:0] instr);
    rst_n = r; flush = f;
    bus.in_valid_i = iv; bus.out_ready_i = o;
    bus.in_pc_i = pc; bus.in_instr_i = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic ev, input logic eir, input logic [2:0] ecnt);
    chk({tag, " out_valid"}, {31'b0, bus.out_valid_o}, {31'b0, ev});
    chk({tag, " in_ready"}, {31'b0, bus.in_ready_o}, {31'b0, eir});
    chk({tag, " count"}, {29'b0, count}, {29'b0, ecnt});
    chk({tag, " empty"}, {31'b0, empty}, {31'b0, ecnt == 3'd0});
    chk({tag, " full"}, {31'b0, full}, {31'b0, ecnt == 3'(DEPTH)});
  endtask

  logic [63:0] mq[$];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    chk("reset in_ready", {31'b0, bus.in_ready_o}, 32'd0);
    tick();

    // Directed table.
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, 0, 1, 0, 1, 32'h0, NOP);
    add(0, 1, 0, 32'h0, 32'h0050_0093, 0, 1, 0, 1, 32'h0, NOP);
    add(0, 0, 1, 0, 0, 1, 1, 1, 1, 32'h0, 32'h0050_0093);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 32'h0, ins(32'h0), 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 32'h4, ins(32'h4), 1, 1, 1, 1, 32'h0, ins(32'h0));
    add(0, 1, 0, 32'h8, ins(32'h8), 1, 1, 2, 1, 32'h0, ins(32'h0));
    add(0, 1, 0, 32'hC, ins(32'hC), 1, 1, 3, 1, 32'h0, ins(32'h0));
    add(0, 1, 0, 32'h10, ins(32'h10), 1, 0, 4, 1, 32'h0, ins(32'h0));
    add(0, 1, 1, 32'h10, ins(32'h10), 1, 0, 4, 1, 32'h0, ins(32'h0));
    add(0, 1, 1, 32'h10, ins(32'h10), 1, 1, 3, 1, 32'h4, ins(32'h4));
    add(0, 0, 1, 0, 0, 1, 1, 3, 1, 32'h8, ins(32'h8));
    add(0, 0, 1, 0, 0, 1, 1, 2, 1, 32'hC, ins(32'hC));
    add(0, 0, 1, 0, 0, 1, 1, 1, 1, 32'h10, ins(32'h10));
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      add(0, 1, 1, 32'(4 * k), ins(32'(4 * k)), k > 0, 1, (k > 0) ? 1 : 0,
          k > 0, 32'(4 * (k - 1)), ins(32'(4 * (k - 1))));
    end
    add(0, 0, 1, 0, 0, 1, 1, 1, 1, 32'h2C, ins(32'h2C));
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 32'h50, ins(32'h50), 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 32'h54, ins(32'h54), 1, 1, 1, 1, 32'h50, ins(32'h50));
    add(0, 1, 0, 32'h58, ins(32'h58), 1, 1, 2, 1, 32'h50, ins(32'h50));
    add(1, 1, 1, 32'h100, ins(32'h100), 0, 1, 3, 0, 0, 0);
    add(0, 1, 0, 32'h200, ins(32'h200), 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1, 1, 1, 32'h200, ins(32'h200));
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(1'b1, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].pc, vecs[i].instr);
      @(negedge clk);
      check_status(tag, vecs[i].ev, vecs[i].eir, vecs[i].ecnt);
      if (vecs[i].chkd) begin
        chk({tag, " out_pc"}, bus.out_pc_o, vecs[i].epc);
        chk({tag, " out_instr"}, bus.out_instr_o, vecs[i].einstr);
      end
      tick();
    end

    // Reset in the middle of a stream holding two entries.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, ins(32'h300)); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h304, ins(32'h304)); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h308, ins(32'h308));
    @(negedge clk);
    chk("midreset in_ready", {31'b0, bus.in_ready_o}, 32'd0);
    chk("midreset count before", {29'b0, count}, 32'd2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    check_status("postreset", 1'b0, 1'b1, 3'd0);
    chk("postreset out_pc", bus.out_pc_o, 32'h0);
    chk("postreset out_instr", bus.out_instr_o, NOP);
    tick();

    // Random traffic against a queue model.
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic r, f, iv, o, e_full, e_ir, e_ov, e_push, e_pop;
      logic [31:0] pc, instr;
      r = ($urandom_range(0, 63) != 0);
      f = ($urandom_range(0, 19) == 0);
      iv = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      pc = $urandom;
      instr = $urandom;
      drive(r, f, iv, o, pc, instr);
      e_full = (mq.size() == DEPTH);
      e_ir = r && !e_full;
      e_ov = (mq.size() > 0) && !f;
      e_push = iv && e_ir && !f;
      e_pop = e_ov && o;
      @(negedge clk);
      check_status("rand", e_ov, e_ir, 3'(mq.size()));
      if (e_ov) begin
        chk("rand out_pc", bus.out_pc_o, mq[0][63:32]);
        chk("rand out_instr", bus.out_instr_o, mq[0][31:0]);
      end
      if (!r || f) begin
        mq.delete();
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (e_push) mq.push_back({pc, instr});
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
